// File: rtl/drum_pkg.sv
// Shared constants and FSM encoding for the drum-column audio output path.
package drum_pkg;

  // Node amplitude format: signed 1.17 fixed point.
  localparam int NODE_W    = 18;
  localparam int NODE_FRAC = 17;

  // Codec word width; the node value is left-justified into it.
  localparam int AUDIO_W  = 32;
  localparam int LJ_SHIFT = AUDIO_W - NODE_W;  // 14

  typedef enum logic [1:0] {
    WAIT_DONE = 2'd0,
    CAPTURE   = 2'd1,
    ISSUE     = 2'd2,
    WAIT_BUSY = 2'd3
  } stream_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Register-array FIFO with first-word-fall-through head output.
module sample_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push   = push && (count != FULL_COUNT);
  assign do_pop    = pop && (count != '0);
  assign head_data = mem[rd_ptr];

  // Storage write; no reset needed since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally (power-of-two depth); count tracks occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/drum_audio_streamer.sv
// Captures the center-node amplitude after each column iteration, converts it
// to a left-justified audio word, buffers it and paces the columns.
module drum_audio_streamer
  import drum_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int VOL_SHIFT  = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          column_done,
  input  logic signed [NODE_W-1:0]      center_node,
  output logic                          iteration_enable,
  output logic                          sample_valid,
  output logic signed [AUDIO_W-1:0]     sample_data,
  input  logic                          sample_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   underrun_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  stream_state_t     state_q;
  stream_state_t     state_d;
  logic              push;
  logic              pop;
  logic              issue_q;
  logic [AUDIO_W-1:0] lj_word;
  logic [AUDIO_W-1:0] audio_word;
  logic [AUDIO_W-1:0] head_data;

  assign lj_word    = {center_node, {LJ_SHIFT{1'b0}}};
  assign audio_word = $signed(lj_word) >>> VOL_SHIFT;
  assign pop        = sample_valid && sample_ready;

  // Next-state and push decode; full test uses the registered count.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      WAIT_DONE: if (column_done) state_d = CAPTURE;
      CAPTURE: begin
        if (fifo_count != FULL_COUNT) begin
          push    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE:     state_d = WAIT_BUSY;
      WAIT_BUSY: if (!column_done) state_d = WAIT_DONE;
      default:   state_d = WAIT_DONE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= WAIT_DONE;
    else       state_q <= state_d;
  end

  // Enable pulse is registered so it is high exactly during ISSUE.
  always_ff @(posedge clk) begin
    if (reset) issue_q <= 1'b0;
    else       issue_q <= push;
  end

  // Masked by reset so a reset landing in ISSUE suppresses that pulse.
  assign iteration_enable = issue_q && !reset;

  // Saturating count of cycles the codec asked for data we did not have.
  always_ff @(posedge clk) begin
    if (reset) begin
      underrun_count <= '0;
    end else if (sample_ready && (fifo_count == '0) && (underrun_count != '1)) begin
      underrun_count <= underrun_count + 1'b1;
    end
  end

  sample_fifo #(
    .WIDTH (AUDIO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (audio_word),
    .pop       (pop),
    .head_data (head_data),
    .count     (fifo_count)
  );

  assign sample_valid = (fifo_count != '0);
  assign sample_data  = sample_valid ? $signed(head_data) : '0;

endmodule

// File: tb/tb_drum_audio_streamer.sv
// Directed bench for drum_audio_streamer (default instance plus VOL_SHIFT=2).
module tb_drum_audio_streamer;

  logic               clk = 1'b0;
  logic               reset;
  logic               column_done;
  logic signed [17:0] center_node;
  logic               sample_ready;

  logic               ie;
  logic               sample_valid;
  logic signed [31:0] sample_data;
  logic [3:0]         fifo_count;
  logic [15:0]        underrun_count;

  logic               ie2;
  logic               valid2;
  logic signed [31:0] data2;
  logic [3:0]         count2;
  logic [15:0]        under2;

  int errors = 0;
  int checks = 0;
  logic [31:0] got_q[$];

  always #5 clk = ~clk;

  drum_audio_streamer #(.FIFO_DEPTH(8), .VOL_SHIFT(0)) dut (
    .clk(clk), .reset(reset), .column_done(column_done), .center_node(center_node),
    .iteration_enable(ie), .sample_valid(sample_valid), .sample_data(sample_data),
    .sample_ready(sample_ready), .fifo_count(fifo_count), .underrun_count(underrun_count)
  );

  drum_audio_streamer #(.FIFO_DEPTH(8), .VOL_SHIFT(2)) dut2 (
    .clk(clk), .reset(reset), .column_done(column_done), .center_node(center_node),
    .iteration_enable(ie2), .sample_valid(valid2), .sample_data(data2),
    .sample_ready(sample_ready), .fifo_count(count2), .underrun_count(under2)
  );

  function automatic logic [31:0] lj(input logic [17:0] v);
    return {v, 14'b0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    column_done = 1'b0;
    sample_ready = 1'b0;
    step();
    reset = 1'b0;
  endtask

  // One column iteration: done rises, push happens, done falls back.
  task automatic feed(input logic [17:0] v);
    column_done = 1'b1;
    center_node = v;
    step();
    step();
    column_done = 1'b0;
    step();
    step();
  endtask

  // Pops up to n words with ready held high; bounded by a cycle budget.
  task automatic drain_collect(input int n, output int cycles);
    got_q.delete();
    cycles = 0;
    sample_ready = 1'b1;
    for (int c = 0; c < 40 && got_q.size() < n; c++) begin
      if (sample_valid) got_q.push_back(sample_data);
      step();
      cycles++;
    end
    sample_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    column_done = 1'b0;
    center_node = '0;
    sample_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    checks++; if (ie !== 1'b0) begin errors++; $display("FAIL reset_ie: got %b expected 0", ie); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", sample_valid); end
    checks++; if (sample_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 00000000", sample_data); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    checks++; if (underrun_count !== 16'h0) begin errors++; $display("FAIL reset_underrun: got %h expected 0000", underrun_count); end
  endtask

  task automatic test_basic_capture();
    int pulses = 0;
    int first_pulse = -1;
    int accepted = 0;
    logic [31:0] last_word = '0;
    apply_reset();
    column_done = 1'b1;
    center_node = 18'h08000;
    sample_ready = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (ie) begin
        pulses++;
        if (first_pulse < 0) first_pulse = c;
      end
      if (sample_valid && sample_ready) begin
        accepted++;
        last_word = sample_data;
      end
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL basic_pulses: got %0d expected 1", pulses); end
    checks++; if (first_pulse !== 2) begin errors++; $display("FAIL basic_pulse_latency: got %0d expected 2", first_pulse); end
    checks++; if (accepted !== 1) begin errors++; $display("FAIL basic_accepted: got %0d expected 1", accepted); end
    checks++; if (last_word !== 32'h20000000) begin errors++; $display("FAIL basic_word: got %h expected 20000000", last_word); end
    column_done = 1'b0;
    sample_ready = 1'b0;
    step();
    step();
  endtask

  task automatic test_negative();
    apply_reset();
    column_done = 1'b1;
    center_node = 18'h3FFFF;
    step();
    step();
    checks++; if (sample_data !== 32'hFFFFC000) begin errors++; $display("FAIL neg_shift0: got %h expected FFFFC000", sample_data); end
    checks++; if (data2 !== 32'hFFFFF000) begin errors++; $display("FAIL neg_shift2: got %h expected FFFFF000", data2); end
    checks++; if (valid2 !== 1'b1) begin errors++; $display("FAIL neg_valid2: got %b expected 1", valid2); end
    column_done = 1'b0;
    sample_ready = 1'b1;
    step();
    sample_ready = 1'b0;
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL neg_count_after_pop: got %0d expected 0", fifo_count); end
    checks++; if (sample_data !== 32'h0) begin errors++; $display("FAIL neg_data_empty: got %h expected 00000000", sample_data); end
    step();
  endtask

  task automatic test_backpressure();
    int pulses = 0;
    bit got;
    int cycles;
    apply_reset();
    for (int i = 1; i <= 9; i++) begin
      column_done = 1'b1;
      center_node = 18'(i);
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
        step();
        if (ie) got = 1'b1;
      end
      if (got) pulses++;
      if (i <= 8) begin
        column_done = 1'b0;
        step();
        step();
      end
    end
    checks++; if (pulses !== 8) begin errors++; $display("FAIL bp_pulses: got %0d expected 8", pulses); end
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL bp_full_count: got %0d expected 8", fifo_count); end
    sample_ready = 1'b1;
    step();
    sample_ready = 1'b0;
    checks++; if (fifo_count !== 4'd7) begin errors++; $display("FAIL bp_after_pop: got %0d expected 7", fifo_count); end
    checks++; if (ie !== 1'b0) begin errors++; $display("FAIL bp_no_pulse_at_pop: got %b expected 0", ie); end
    step();
    checks++; if (ie !== 1'b1) begin errors++; $display("FAIL bp_ninth_pulse: got %b expected 1", ie); end
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL bp_ninth_push: got %0d expected 8", fifo_count); end
    column_done = 1'b0;
    step();
    drain_collect(8, cycles);
    checks++; if (cycles !== 8) begin errors++; $display("FAIL bp_drain_bubbles: got %0d cycles expected 8", cycles); end
    checks++; if (got_q.size() !== 8) begin errors++; $display("FAIL bp_drain_size: got %0d expected 8", got_q.size()); end
    for (int k = 0; k < 8 && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== lj(18'(k + 2))) begin
        errors++; $display("FAIL bp_order[%0d]: got %h expected %h", k, got_q[k], lj(18'(k + 2)));
      end
    end
    // the 1st word was popped to unblock the 9th capture
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL bp_empty: got %0d expected 0", fifo_count); end
  endtask

  task automatic test_simultaneous();
    logic [17:0] v [11];
    int cycles;
    apply_reset();
    for (int k = 0; k < 11; k++) v[k] = 18'h01000 + 18'(k * 17);
    for (int k = 0; k < 3; k++) feed(v[k]);
    checks++; if (fifo_count !== 4'd3) begin errors++; $display("FAIL sim_preload: got %0d expected 3", fifo_count); end
    for (int k = 3; k < 11; k++) begin
      column_done = 1'b1;
      center_node = v[k];
      step();
      sample_ready = 1'b1;
      checks++;
      if (sample_data !== lj(v[k - 3])) begin
        errors++; $display("FAIL sim_head[%0d]: got %h expected %h", k, sample_data, lj(v[k - 3]));
      end
      step();
      sample_ready = 1'b0;
      column_done = 1'b0;
      checks++;
      if (fifo_count !== 4'd3) begin
        errors++; $display("FAIL sim_count[%0d]: got %0d expected 3", k, fifo_count);
      end
      step();
      step();
    end
    drain_collect(3, cycles);
    checks++; if (got_q.size() !== 3) begin errors++; $display("FAIL sim_drain_size: got %0d expected 3", got_q.size()); end
    for (int k = 0; k < 3 && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== lj(v[k + 8])) begin
        errors++; $display("FAIL sim_tail[%0d]: got %h expected %h", k, got_q[k], lj(v[k + 8]));
      end
    end
  endtask

  task automatic test_underrun();
    apply_reset();
    sample_ready = 1'b1;
    for (int c = 0; c < 5; c++) step();
    checks++; if (underrun_count !== 16'd5) begin errors++; $display("FAIL underrun_5: got %0d expected 5", underrun_count); end
    for (int c = 0; c < 65529; c++) step();
    checks++; if (underrun_count !== 16'hFFFE) begin errors++; $display("FAIL underrun_fffe: got %h expected FFFE", underrun_count); end
    for (int c = 0; c < 4; c++) step();
    checks++; if (underrun_count !== 16'hFFFF) begin errors++; $display("FAIL underrun_sat: got %h expected FFFF", underrun_count); end
    sample_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    apply_reset();
    sample_ready = 1'b1;
    step();
    step();
    sample_ready = 1'b0;
    feed(18'h00011);
    feed(18'h00022);
    feed(18'h00033);
    column_done = 1'b1;
    center_node = 18'h00044;
    step();
    step();
    checks++; if (fifo_count !== 4'd4) begin errors++; $display("FAIL mr_count4: got %0d expected 4", fifo_count); end
    checks++; if (ie !== 1'b1) begin errors++; $display("FAIL mr_in_issue: got %b expected 1", ie); end
    reset = 1'b1;
    #1;
    checks++; if (ie !== 1'b0) begin errors++; $display("FAIL mr_ie_during_reset: got %b expected 0", ie); end
    step();
    checks++; if (ie !== 1'b0) begin errors++; $display("FAIL mr_ie_after: got %b expected 0", ie); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL mr_valid: got %b expected 0", sample_valid); end
    checks++; if (sample_data !== 32'h0) begin errors++; $display("FAIL mr_data: got %h expected 00000000", sample_data); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL mr_count: got %0d expected 0", fifo_count); end
    checks++; if (underrun_count !== 16'd0) begin errors++; $display("FAIL mr_underrun: got %0d expected 0", underrun_count); end
    reset = 1'b0;
    column_done = 1'b0;
    step();
    column_done = 1'b1;
    center_node = 18'h00ABC;
    step();
    checks++; if (ie !== 1'b0) begin errors++; $display("FAIL mr_resume_early: got %b expected 0", ie); end
    step();
    checks++; if (ie !== 1'b1) begin errors++; $display("FAIL mr_resume_pulse: got %b expected 1", ie); end
    checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL mr_resume_count: got %0d expected 1", fifo_count); end
    checks++; if (sample_data !== 32'h02AF0000) begin errors++; $display("FAIL mr_resume_data: got %h expected 02AF0000", sample_data); end
    column_done = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_basic_capture();
    test_negative();
    test_backpressure();
    test_simultaneous();
    test_underrun();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
